// File: rtl/morse_encoder_fifo.sv
// Morse transmitter: ASCII bytes queue in a FIFO and play out as timed marks/gaps.
// Define MORSE_DIGITS_EN to add '0'-'9' to the table.
module morse_encoder_fifo #(
    parameter int UNIT_TICKS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_char,
    output logic                          key_out,
    output logic                          led_mavi,
    output logic                          led_kirmizi,
    output logic                          busy,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(UNIT_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, MARK, GAP_ELEM, GAP_CHAR, GAP_WORD
    } state_t;

    // {length, pattern left-aligned, 1 = dash}; length 0 = not in table
    function automatic logic [7:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        lookup = 8'h00;
        case (u)
            8'h41: lookup = {3'd2, 5'b01000};
            8'h42: lookup = {3'd4, 5'b10000};
            8'h43: lookup = {3'd4, 5'b10100};
            8'h44: lookup = {3'd3, 5'b10000};
            8'h45: lookup = {3'd1, 5'b00000};
            8'h46: lookup = {3'd4, 5'b00100};
            8'h47: lookup = {3'd3, 5'b11000};
            8'h48: lookup = {3'd4, 5'b00000};
            8'h49: lookup = {3'd2, 5'b00000};
            8'h4A: lookup = {3'd4, 5'b01110};
            8'h4B: lookup = {3'd3, 5'b10100};
            8'h4C: lookup = {3'd4, 5'b01000};
            8'h4D: lookup = {3'd2, 5'b11000};
            8'h4E: lookup = {3'd2, 5'b10000};
            8'h4F: lookup = {3'd3, 5'b11100};
            8'h50: lookup = {3'd4, 5'b01100};
            8'h51: lookup = {3'd4, 5'b11010};
            8'h52: lookup = {3'd3, 5'b01000};
            8'h53: lookup = {3'd3, 5'b00000};
            8'h54: lookup = {3'd1, 5'b10000};
            8'h55: lookup = {3'd3, 5'b00100};
            8'h56: lookup = {3'd4, 5'b00010};
            8'h57: lookup = {3'd3, 5'b01100};
            8'h58: lookup = {3'd4, 5'b10010};
            8'h59: lookup = {3'd4, 5'b10110};
            8'h5A: lookup = {3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
            8'h30: lookup = {3'd5, 5'b11111};
            8'h31: lookup = {3'd5, 5'b01111};
            8'h32: lookup = {3'd5, 5'b00111};
            8'h33: lookup = {3'd5, 5'b00011};
            8'h34: lookup = {3'd5, 5'b00001};
            8'h35: lookup = {3'd5, 5'b00000};
            8'h36: lookup = {3'd5, 5'b10000};
            8'h37: lookup = {3'd5, 5'b11000};
            8'h38: lookup = {3'd5, 5'b11100};
            8'h39: lookup = {3'd5, 5'b11110};
`else
`endif
            default: lookup = 8'h00;
        endcase
    endfunction

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop;

    state_t        state;
    logic [TW-1:0] tick;
    logic [2:0]    unit, dur, rem;
    logic [4:0]    cur_pat;
    logic [2:0]    ch_len, st_len;
    logic [4:0]    ch_pat, st_pat;
    logic          ch_space, ch_bad, st_space;
    logic [7:0]    hd, hd_code;
    logic          hd_space, hd_bad;
    logic          done, gap_last, launch, idle_next;

    assign in_ready   = count != CW'(FIFO_DEPTH);
    assign fifo_count = count;
    assign push       = in_valid && in_ready;

    assign hd       = mem[rd_ptr];
    assign hd_code  = lookup(hd);
    assign hd_space = hd == 8'h20;
    assign hd_bad   = !hd_space && hd_code[7:5] == 3'd0;

    always_comb begin
        dur = 3'd1;
        unique case (state)
            MARK:     dur = cur_pat[4] ? 3'd3 : 3'd1;
            GAP_CHAR: dur = 3'd3;
            GAP_WORD: dur = 3'd4;
            default:  dur = 3'd1;
        endcase
    end

    assign done     = tick == TW'(UNIT_TICKS - 1) && unit == dur - 3'd1;
    assign gap_last = (state == GAP_CHAR || state == GAP_WORD) && done;
    assign pop      = count != '0 && (state == IDLE || gap_last);

    // A finishing gap hands straight over to the next queued character,
    // so back-to-back characters carry no state-transition overhead.
    assign launch = (state == LOAD && !ch_bad)
                 || (gap_last && count != '0 && !hd_bad);
    assign idle_next = (state == IDLE && !pop)
                    || (state == LOAD && ch_bad)
                    || (gap_last && count == '0);

    assign st_len   = (state == LOAD) ? ch_len   : hd_code[7:5];
    assign st_pat   = (state == LOAD) ? ch_pat   : hd_code[4:0];
    assign st_space = (state == LOAD) ? ch_space : hd_space;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick        <= '0;
            unit        <= '0;
            rem         <= '0;
            cur_pat     <= '0;
            ch_len      <= '0;
            ch_pat      <= '0;
            ch_space    <= 1'b0;
            ch_bad      <= 1'b0;
            key_out     <= 1'b0;
            led_mavi    <= 1'b0;
            led_kirmizi <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            err  <= 1'b0;
            busy <= count_next != '0 || !idle_next;
            if (launch) begin
                tick        <= '0;
                unit        <= '0;
                cur_pat     <= st_pat;
                rem         <= st_len;
                state       <= st_space ? GAP_WORD : MARK;
                key_out     <= !st_space;
                led_mavi    <= !st_space && !st_pat[4];
                led_kirmizi <= !st_space && st_pat[4];
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pop) begin
                            ch_len   <= hd_code[7:5];
                            ch_pat   <= hd_code[4:0];
                            ch_space <= hd_space;
                            ch_bad   <= hd_bad;
                            err      <= hd_bad;
                            state    <= LOAD;
                        end
                    end
                    LOAD: state <= IDLE;
                    MARK, GAP_ELEM, GAP_CHAR, GAP_WORD: begin
                        if (!done) begin
                            if (tick == TW'(UNIT_TICKS - 1)) begin
                                tick <= '0;
                                unit <= unit + 3'd1;
                            end else begin
                                tick <= tick + TW'(1);
                            end
                        end else begin
                            tick <= '0;
                            unit <= '0;
                            if (state == MARK) begin
                                key_out     <= 1'b0;
                                led_mavi    <= 1'b0;
                                led_kirmizi <= 1'b0;
                                cur_pat     <= cur_pat << 1;
                                rem         <= rem - 3'd1;
                                state       <= (rem == 3'd1) ? GAP_CHAR : GAP_ELEM;
                            end else if (state == GAP_ELEM) begin
                                key_out     <= 1'b1;
                                led_mavi    <= !cur_pat[4];
                                led_kirmizi <= cur_pat[4];
                                state       <= MARK;
                            end else if (count == '0) begin
                                state <= IDLE;
                            end else begin
                                ch_bad <= 1'b1;
                                err    <= 1'b1;
                                state  <= LOAD;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder_fifo.sv
// Directed bench for morse_encoder_fifo at UNIT_TICKS=2, FIFO_DEPTH=4.
// Key/LED activity is logged as run lengths of {key,mavi,kirmizi} while busy.
module tb_morse_encoder_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       key_out, led_mavi, led_kirmizi, busy, err;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;

    int runs[$];
    int exp_q[$];
    int cur_v = 0;
    int cur_n = 0;
    int key_hi = 0;
    int err_cnt = 0;

    morse_encoder_fifo #(.UNIT_TICKS(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_char(in_char),
        .key_out(key_out),
        .led_mavi(led_mavi),
        .led_kirmizi(led_kirmizi),
        .busy(busy),
        .err(err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        int v;
        v = int'({key_out, led_mavi, led_kirmizi});
        if (key_out) key_hi++;
        if (err) err_cnt++;
        if (busy) begin
            if (cur_n > 0 && v == cur_v) begin
                cur_n++;
            end else begin
                if (cur_n > 0) runs.push_back(cur_v * 1000 + cur_n);
                cur_v = v;
                cur_n = 1;
            end
        end else if (cur_n > 0) begin
            runs.push_back(cur_v * 1000 + cur_n);
            cur_n = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // '.' dot, '-' dash, ' ' letter boundary, '/' word boundary
    function automatic void build(input string s);
        bit pm;
        exp_q.delete();
        exp_q.push_back(2);
        pm = 0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                8'h2E: begin
                    if (pm) exp_q.push_back(2);
                    exp_q.push_back(6002);
                    pm = 1;
                end
                8'h2D: begin
                    if (pm) exp_q.push_back(2);
                    exp_q.push_back(5006);
                    pm = 1;
                end
                8'h20: begin exp_q.push_back(6); pm = 0; end
                8'h2F: begin exp_q.push_back(14); pm = 0; end
                default: ;
            endcase
        end
        exp_q.push_back(6);
    endfunction

    task automatic compare_runs(input string tag);
        check({tag, "_nruns"}, runs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i),
                  (i < runs.size()) ? runs[i] : -1, exp_q[i]);
    endtask

    task automatic send(input logic [7:0] c);
        int g;
        in_char  = c;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("send_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic play(input string chars, input string morse, input string tag);
        runs.delete();
        send_str(chars);
        wait_idle();
        build(morse);
        compare_runs(tag);
    endtask

    initial begin
        int k0, e0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_char  = 8'h45;
        repeat (3) @(negedge clk);
        check("rst_key", key_out, 0);
        check("rst_mavi", led_mavi, 0);
        check("rst_kirmizi", led_kirmizi, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_count", fifo_count, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);
        check("rel_count", fifo_count, 0);

        play("E", ".", "E");
        play("a", ".-", "a");
        play("E E", "./.", "E_sp_E");

        k0 = key_hi;
        e0 = err_cnt;
        runs.delete();
        send_str("#");
        wait_idle();
        exp_q.delete();
        exp_q.push_back(2);
        compare_runs("hash");
        check("hash_err", err_cnt - e0, 1);
        check("hash_key", key_hi - k0, 0);

        k0 = key_hi;
        e0 = err_cnt;
`ifdef MORSE_DIGITS_EN
        play("7", "--...", "seven");
        check("seven_err", err_cnt - e0, 0);
`else
        runs.delete();
        send_str("7");
        wait_idle();
        check("seven_err", err_cnt - e0, 1);
        check("seven_key", key_hi - k0, 0);
`endif

        runs.delete();
        send(8'h45);
        send(8'h54);
        send(8'h49);
        send(8'h41);
        send(8'h4E);
        check("full_ready", in_ready, 0);
        check("full_count", fifo_count, 4);
        send(8'h4D);
        in_valid = 1'b0;
        wait_idle();
        build(". - .. .- -. --");
        compare_runs("fifo_order");

        send_str("TEEE");
        begin
            int g;
            g = 0;
            while (!led_kirmizi && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        check("mid_dash", led_kirmizi, 1);
        check("mid_count", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_key", key_out, 0);
        check("arst_kirmizi", led_kirmizi, 0);
        check("arst_busy", busy, 0);
        check("arst_count", fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        k0 = key_hi;
        repeat (40) @(negedge clk);
        check("post_key", key_hi - k0, 0);
        check("post_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
